// File: rtl/truth_table_sweeper_pkg.sv
// Shared encodings and widths for the truth-table sweeper.
package truth_table_sweeper_pkg;

   localparam int unsigned VecWidth   = 4;
   localparam int unsigned TableWidth = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/truth_table_sweeper_popcount16.sv
// Combinational ones count of a 16-bit word (result 0..16).
module popcount16
   import truth_table_sweeper_pkg::*;
(
   input  logic [TableWidth-1:0] value,
   output logic [4:0]            count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < TableWidth; i++) begin
         count = count + 5'(value[i]);
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 4-input combinational function through all 16 input vectors and
// captures its truth table, ones count and a pass flag against a reference.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int unsigned           HOLD_CYCLES = 4,
   parameter logic [TableWidth-1:0] EXPECTED    = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  f,
   output logic                  A,
   output logic                  B,
   output logic                  C,
   output logic                  D,
   output logic                  busy,
   output logic                  done,
   output logic                  table_valid,
   output logic [TableWidth-1:0] truth_table,
   output logic [4:0]            ones,
   output logic                  pass
);

   localparam int unsigned CntWidth = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HOLD_CYCLES - 1);

   state_e                state;
   logic [VecWidth-1:0]   vector;
   logic [CntWidth-1:0]   hold_cnt;
   logic [4:0]            table_ones;

   // Vector register is cleared outside a sweep, so IDLE presents 0.
   assign {A, B, C, D} = vector;

   popcount16 u_popcount (
      .value (truth_table),
      .count (table_ones)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StIdle;
         vector      <= '0;
         hold_cnt    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         table_valid <= 1'b0;
         truth_table <= '0;
         ones        <= '0;
         pass        <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (start) begin
                  state       <= StRun;
                  vector      <= '0;
                  hold_cnt    <= '0;
                  truth_table <= '0;
                  table_valid <= 1'b0;
                  pass        <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            StRun: begin
               if (hold_cnt == HoldLast) begin
                  truth_table[vector] <= f;
                  hold_cnt            <= '0;
                  if (vector == 4'hF) begin
                     state <= StDone;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     vector <= vector + 4'd1;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            StDone: begin
               state       <= StIdle;
               done        <= 1'b0;
               table_valid <= 1'b1;
               ones        <= table_ones;
               pass        <= (truth_table == EXPECTED);
               vector      <= '0;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench: four sweepers with different hold lengths and functions, table-driven sweeps
// plus abort-by-reset and ignored/back-to-back start sequences.
module tb_truth_table_sweeper;

   typedef struct {
      int          sel;
      int          h;
      logic [15:0] tt;
      logic [4:0]  ones;
      logic        pass;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [3:0]  start_v;
   logic [3:0]  f_v;
   logic [3:0]  a_v, b_v, c_v, d_v, busy_v, done_v, tv_v, pass_v;
   logic [15:0] tt_v [4];
   logic [4:0]  ones_v [4];

   int   n_cmp = 0;
   int   n_err = 0;
   vec_t sb_q[$];
   vec_t vecs[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Functions under test: D, A&B, A, constant 1.
   always_comb f_v = {1'b1, a_v[2], a_v[1] & b_v[1], d_v[0]};

   truth_table_sweeper #(.HOLD_CYCLES(4)) u_d0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .f(f_v[0]),
      .A(a_v[0]), .B(b_v[0]), .C(c_v[0]), .D(d_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .table_valid(tv_v[0]),
      .truth_table(tt_v[0]), .ones(ones_v[0]), .pass(pass_v[0])
   );
   truth_table_sweeper #(.HOLD_CYCLES(1), .EXPECTED(16'hF000)) u_d1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .f(f_v[1]),
      .A(a_v[1]), .B(b_v[1]), .C(c_v[1]), .D(d_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .table_valid(tv_v[1]),
      .truth_table(tt_v[1]), .ones(ones_v[1]), .pass(pass_v[1])
   );
   truth_table_sweeper #(.HOLD_CYCLES(2), .EXPECTED(16'h0000)) u_d2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .f(f_v[2]),
      .A(a_v[2]), .B(b_v[2]), .C(c_v[2]), .D(d_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .table_valid(tv_v[2]),
      .truth_table(tt_v[2]), .ones(ones_v[2]), .pass(pass_v[2])
   );
   truth_table_sweeper #(.HOLD_CYCLES(3), .EXPECTED(16'hFFFF)) u_d3 (
      .clk(clk), .rst(rst), .start(start_v[3]), .f(f_v[3]),
      .A(a_v[3]), .B(b_v[3]), .C(c_v[3]), .D(d_v[3]),
      .busy(busy_v[3]), .done(done_v[3]), .table_valid(tv_v[3]),
      .truth_table(tt_v[3]), .ones(ones_v[3]), .pass(pass_v[3])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [28:0] all_outs(input int sel);
      return {a_v[sel], b_v[sel], c_v[sel], d_v[sel], busy_v[sel], done_v[sel], tv_v[sel],
              pass_v[sel], ones_v[sel], tt_v[sel]};
   endfunction

   // Called at a negedge; start is sampled at the next posedge (edge 0).
   // Returns at the negedge after edge 16h+1 with start low.
   task automatic run_sweep(input int sel, input int h, input logic [15:0] tt,
                            input logic [4:0] ones, input logic pass, input bit poke);
      vec_t       e;
      int         busy_n = 0;
      int         done_n = 0;
      int         done_at = -1;
      int         vec_bad = 0;
      logic [3:0] vec;
      e.sel = sel; e.h = h; e.tt = tt; e.ones = ones; e.pass = pass;
      sb_q.push_back(e);
      start_v[sel] = 1'b1;
      @(negedge clk);
      start_v[sel] = 1'b0;
      chk("busy_after_start", 32'(busy_v[sel]), 32'd1);
      chk("valid_cleared_on_start", 32'(tv_v[sel]), 32'd0);
      for (int k = 0; k <= 16 * h + 1; k++) begin
         if (k > 0) @(negedge clk);
         vec = {a_v[sel], b_v[sel], c_v[sel], d_v[sel]};
         if (k < 16 * h && vec !== 4'(k / h)) vec_bad++;
         if (busy_v[sel]) busy_n++;
         if (done_v[sel]) begin
            done_n++;
            if (done_at < 0) done_at = k;
         end
         // Extra starts mid-RUN and during DONE must be ignored.
         start_v[sel] = (poke && (k == 8 * h || k == 16 * h)) ? 1'b1 : 1'b0;
      end
      start_v[sel] = 1'b0;
      chk("vector_sequence_errors", 32'(vec_bad), 32'd0);
      chk("busy_cycles", 32'(busy_n), 32'(16 * h));
      chk("done_pulse_count", 32'(done_n), 32'd1);
      chk("done_edge", 32'(done_at), 32'(16 * h));
      chk("busy_idle", 32'(busy_v[sel]), 32'd0);
      chk("vector_idle", 32'({a_v[sel], b_v[sel], c_v[sel], d_v[sel]}), 32'd0);
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk("table", 32'(tt_v[sel]), 32'(e.tt));
         chk("ones", 32'(ones_v[sel]), 32'(e.ones));
         chk("pass", 32'(pass_v[sel]), 32'(e.pass));
         chk("table_valid", 32'(tv_v[sel]), 32'd1);
      end
   endtask

   initial begin
      int done_seen;
      int tv_seen;
      rst     = 1'b1;
      start_v = '0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 4; s++) chk("reset_outputs", 32'(all_outs(s)), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      vecs[0] = '{sel: 0, h: 4, tt: 16'hAAAA, ones: 5'd8,  pass: 1'b0};
      vecs[1] = '{sel: 1, h: 1, tt: 16'hF000, ones: 5'd4,  pass: 1'b1};
      vecs[2] = '{sel: 2, h: 2, tt: 16'hFF00, ones: 5'd8,  pass: 1'b0};
      vecs[3] = '{sel: 3, h: 3, tt: 16'hFFFF, ones: 5'd16, pass: 1'b1};
      for (int i = 0; i < 4; i++) begin
         run_sweep(vecs[i].sel, vecs[i].h, vecs[i].tt, vecs[i].ones, vecs[i].pass, 1'b0);
         @(negedge clk);
      end

      // Abort an H=4 sweep with reset shortly after edge 19.
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (19) @(negedge clk);
      chk("busy_before_abort", 32'(busy_v[0]), 32'd1);
      #2 rst = 1'b1;
      #1 chk("async_reset_outputs", 32'(all_outs(0)), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      tv_seen   = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (done_v[0]) done_seen++;
         if (tv_v[0]) tv_seen++;
      end
      chk("no_done_after_abort", 32'(done_seen), 32'd0);
      chk("no_valid_after_abort", 32'(tv_seen), 32'd0);
      run_sweep(0, 4, 16'hAAAA, 5'd8, 1'b0, 1'b0);

      // Ignored starts, then a start right after done is accepted.
      @(negedge clk);
      run_sweep(2, 2, 16'hFF00, 5'd8, 1'b0, 1'b1);
      run_sweep(2, 2, 16'hFF00, 5'd8, 1'b0, 1'b0);
      run_sweep(1, 1, 16'hF000, 5'd4, 1'b1, 1'b1);
      run_sweep(1, 1, 16'hF000, 5'd4, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
